// File: rtl/jtpopeye_dwnld_pkg.sv
// Shared constants and types for the download router.
package jtpopeye_dwnld_pkg;

  // Default start of the PROM area; SDRAM occupies everything below it.
  localparam int DEF_PROM_START = 65536;

  // Encrypted-ROM signature, byte 0 in bits 7:0.
  localparam logic [31:0] DEF_SIG = 32'h46a564e4;

  // PROM region indices, consecutive from the PROM start address.
  localparam int PROM_TIMING    = 0;
  localparam int PROM_OBJ_PAL_B = 1;
  localparam int PROM_OBJ_PAL_A = 2;
  localparam int PROM_TXT_PAL   = 3;
  localparam int PROM_BACK_PAL  = 4;
  localparam int PROM_TXT       = 5;

  // SDRAM write sequencer states.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WR   = 1'b1
  } wr_state_t;

  // Select one byte of the signature word.
  function automatic logic [7:0] sig_byte(input logic [31:0] sig, input logic [1:0] sel);
    return sig[8*sel +: 8];
  endfunction

endpackage

// File: rtl/jtpopeye_dwnld_fifo.sv
// Small synchronous FIFO with full/empty flags and simultaneous push/pop.
// The head is read combinationally so the consumer can capture it in the
// same cycle it pops; at this depth the storage maps to registers/LUT RAM.
module jtpopeye_dwnld_fifo #(
  parameter int WIDTH   = 8,
  parameter int FIFO_AW = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int DEPTH = 1 << FIFO_AW;

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_reg;
  logic [FIFO_AW-1:0] rd_ptr_reg;
  logic [FIFO_AW:0]   count_reg;
  logic               do_push;
  logic               do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Storage write; contents need no reset since the count guards reads.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= din;
  end

  // Pointer and occupancy tracking; push and pop together leave the count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign dout  = mem[rd_ptr_reg];
  assign full  = (count_reg == (FIFO_AW+1)'(DEPTH));
  assign empty = (count_reg == '0);

endmodule

// File: rtl/jtpopeye_dwnld.sv
// Download router: steers ioctl bytes to the SDRAM programming port (through a
// small FIFO) or to one-hot PROM write strobes, checks the encryption signature
// and reports when a finished download has fully drained.
module jtpopeye_dwnld
  import jtpopeye_dwnld_pkg::*;
#(
  parameter int          AW         = 22,
  parameter int          DW         = 16,
  parameter int          PROM_START = DEF_PROM_START,
  parameter int          PROM_CNT   = 6,
  parameter int          PROM_AW    = 8,
  parameter int          FIFO_AW    = 2,
  parameter logic [31:0] SIG        = DEF_SIG,
  localparam int         LW         = $clog2(DW/8)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                downloading,
  input  logic [AW-1:0]       ioctl_addr,
  input  logic [7:0]          ioctl_data,
  input  logic                ioctl_wr,
  output logic                ioctl_wait,
  output logic [AW-LW-1:0]    prog_addr,
  output logic [DW-1:0]       prog_data,
  output logic [DW/8-1:0]     prog_mask,
  output logic                prog_we,
  input  logic                prog_rdy,
  output logic [PROM_AW-1:0]  prom_addr,
  output logic [7:0]          prom_data,
  output logic [PROM_CNT-1:0] prom_we,
  output logic                encrypted,
  output logic                overflow,
  output logic                done
);

  localparam int LANES = DW / 8;
  // Lane field is kept one bit wide (always zero) when DW=8 so the FIFO entry stays well formed.
  localparam int LWX = (LW > 0) ? LW : 1;
  localparam int PAW = AW - LW;
  localparam int EW  = PAW + LWX + 8;
  localparam logic [AW-1:0] PROM_BASE = AW'(PROM_START);

  logic                dl_last_reg;
  logic                dl_rise;
  logic                dl_fall;
  logic                sdram_sel;
  logic                push;
  logic                pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [LWX-1:0]      push_lane;
  logic [EW-1:0]       fifo_din;
  logic [EW-1:0]       fifo_dout;
  logic [PAW-1:0]      head_addr;
  logic [LWX-1:0]      head_lane;
  logic [7:0]          head_data;
  logic [LANES-1:0]    mask_next;
  logic [AW-1:0]       prom_off;
  logic [AW-1:0]       prom_idx;
  logic [PROM_CNT-1:0] prom_hit;
  wr_state_t           state_reg;
  wr_state_t           state_next;
  logic [2:0]          sig_cnt_reg;
  logic                match_reg;
  logic                sig_hit;
  logic                sig_ok;
  logic                pending_reg;

  assign dl_rise   = downloading & ~dl_last_reg;
  assign dl_fall   = ~downloading & dl_last_reg;
  assign sdram_sel = (ioctl_addr < PROM_BASE);
  assign push      = ioctl_wr & sdram_sel & ~fifo_full;

  generate
    if (LW > 0) begin : g_lane
      assign push_lane = ioctl_addr[LW-1:0];
    end else begin : g_nolane
      assign push_lane = '0;
    end
  endgenerate

  assign fifo_din = {ioctl_addr[AW-1:LW], push_lane, ioctl_data};
  assign {head_addr, head_lane, head_data} = fifo_dout;

  jtpopeye_dwnld_fifo #(
    .WIDTH   (EW),
    .FIFO_AW (FIFO_AW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign ioctl_wait = fifo_full;

  // Active-low byte-lane mask: only the addressed lane is enabled.
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_mask
      assign mask_next[gi] = (head_lane != LWX'(gi));
    end
  endgenerate

  // PROM region decode; offsets past the last region match nothing and are dropped.
  assign prom_off = ioctl_addr - PROM_BASE;
  assign prom_idx = prom_off >> PROM_AW;
  generate
    for (gi = 0; gi < PROM_CNT; gi++) begin : g_prom
      assign prom_hit[gi] = ioctl_wr & ~sdram_sel & (prom_idx == AW'(gi));
    end
  endgenerate

  // Sequencer next state: load from the FIFO when idle or when the current write is accepted.
  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = ST_WR;
        end
      end
      ST_WR: begin
        if (prog_rdy) begin
          if (!fifo_empty) pop = 1'b1;
          else             state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign prog_we = (state_reg == ST_WR);

  // Sequencer state and SDRAM request registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      prog_addr <= '0;
      prog_data <= '0;
      prog_mask <= '0;
    end else begin
      state_reg <= state_next;
      if (pop) begin
        prog_addr <= head_addr;
        prog_data <= {LANES{head_data}};
        prog_mask <= mask_next;
      end
    end
  end

  // PROM strobe: one cycle, registered straight from the loader.
  always_ff @(posedge clk) begin
    if (rst) begin
      prom_addr <= '0;
      prom_data <= '0;
      prom_we   <= '0;
    end else begin
      prom_we <= prom_hit;
      if (|prom_hit) begin
        prom_addr <= prom_off[PROM_AW-1:0];
        prom_data <= ioctl_data;
      end
    end
  end

  // Sticky overflow for SDRAM bytes arriving while the FIFO is full.
  always_ff @(posedge clk) begin
    if (rst)                                   overflow <= 1'b0;
    else if (ioctl_wr && sdram_sel && fifo_full) overflow <= 1'b1;
  end

  assign sig_hit = ioctl_wr && (ioctl_addr[AW-1:2] == '0) && (sig_cnt_reg < 3'd4);
  assign sig_ok  = (ioctl_data == sig_byte(SIG, ioctl_addr[1:0]));

  // Signature check over the first four bytes of each download.
  always_ff @(posedge clk) begin
    if (rst) begin
      sig_cnt_reg <= '0;
      match_reg   <= 1'b0;
      encrypted   <= 1'b0;
    end else if (dl_rise) begin
      sig_cnt_reg <= '0;
      match_reg   <= 1'b1;
      encrypted   <= 1'b0;
    end else if (sig_hit) begin
      sig_cnt_reg <= sig_cnt_reg + 3'd1;
      match_reg   <= match_reg & sig_ok;
      if (sig_cnt_reg == 3'd3) encrypted <= match_reg & sig_ok;
    end
  end

  // Download-end tracking: done fires once the FIFO and sequencer have drained.
  always_ff @(posedge clk) begin
    if (rst) begin
      dl_last_reg <= 1'b0;
      pending_reg <= 1'b0;
      done        <= 1'b0;
    end else begin
      dl_last_reg <= downloading;
      done        <= 1'b0;
      if (pending_reg && fifo_empty && (state_reg == ST_IDLE)) begin
        done        <= 1'b1;
        pending_reg <= 1'b0;
      end
      if (dl_fall) pending_reg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_jtpopeye_dwnld.sv
// Self-checking bench for jtpopeye_dwnld with default parameters (DW=16, FIFO_AW=2).
module tb_jtpopeye_dwnld;
  import jtpopeye_dwnld_pkg::*;

  localparam int AW         = 22;
  localparam int DW         = 16;
  localparam int PROM_START = 65536;
  localparam int PROM_CNT   = 6;
  localparam int PROM_AW    = 8;
  localparam int FIFO_AW    = 2;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                downloading = 1'b0;
  logic [AW-1:0]       ioctl_addr = '0;
  logic [7:0]          ioctl_data = '0;
  logic                ioctl_wr = 1'b0;
  logic                ioctl_wait;
  logic [AW-2:0]       prog_addr;
  logic [DW-1:0]       prog_data;
  logic [1:0]          prog_mask;
  logic                prog_we;
  logic                prog_rdy = 1'b0;
  logic [PROM_AW-1:0]  prom_addr;
  logic [7:0]          prom_data;
  logic [PROM_CNT-1:0] prom_we;
  logic                encrypted;
  logic                overflow;
  logic                done;

  typedef struct {
    logic [AW-2:0] addr;
    logic [DW-1:0] data;
    logic [1:0]    mask;
    int            cyc;
  } wr_t;

  wr_t exp_q[$];
  wr_t obs_q[$];
  wr_t mon_w;
  int  obs_rd = 0;
  int  cyc = 0;
  int  checks = 0;
  int  failures = 0;

  jtpopeye_dwnld #(
    .AW (AW), .DW (DW), .PROM_START (PROM_START), .PROM_CNT (PROM_CNT),
    .PROM_AW (PROM_AW), .FIFO_AW (FIFO_AW), .SIG (32'h46a564e4)
  ) dut (
    .clk (clk), .rst (rst), .downloading (downloading),
    .ioctl_addr (ioctl_addr), .ioctl_data (ioctl_data), .ioctl_wr (ioctl_wr),
    .ioctl_wait (ioctl_wait), .prog_addr (prog_addr), .prog_data (prog_data),
    .prog_mask (prog_mask), .prog_we (prog_we), .prog_rdy (prog_rdy),
    .prom_addr (prom_addr), .prom_data (prom_data), .prom_we (prom_we),
    .encrypted (encrypted), .overflow (overflow), .done (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every accepted SDRAM write.
  always @(negedge clk) begin
    if (!rst && prog_we && prog_rdy) begin
      mon_w.addr = prog_addr;
      mon_w.data = prog_data;
      mon_w.mask = prog_mask;
      mon_w.cyc  = cyc;
      obs_q.push_back(mon_w);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sync();
    exp_q.delete();
    obs_rd = obs_q.size();
  endtask

  // One-cycle loader strobe; queue the expected SDRAM write when it should land.
  task automatic send(input logic [AW-1:0] a, input logic [7:0] d, input bit accept);
    ioctl_addr = a;
    ioctl_data = d;
    ioctl_wr   = 1'b1;
    if (accept && (a < PROM_START)) begin
      wr_t e;
      e.addr = a[AW-1:1];
      e.data = {d, d};
      e.mask = a[0] ? 2'b01 : 2'b10;
      e.cyc  = 0;
      exp_q.push_back(e);
    end
    tick();
    ioctl_wr = 1'b0;
  endtask

  task automatic wait_obs(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (obs_q.size() - obs_rd >= n) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (obs_q.size() - obs_rd >= n) ok = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    checks++;
    if ({ioctl_wait, prog_we, prog_addr, prog_data, prog_mask, prom_we, prom_addr,
         prom_data, encrypted, overflow, done} !== '0) begin
      failures++;
      $display("FAIL reset_hold outputs not all zero: we=%b wait=%b prom_we=%h", prog_we, ioctl_wait, prom_we);
    end else $display("ok reset_hold all outputs zero");
    rst = 1'b0;
    tick();
    @(negedge clk);
    checks++;
    if ({ioctl_wait, prog_we, prom_we, encrypted, overflow, done} !== '0) begin
      failures++;
      $display("FAIL reset_release got we=%b wait=%b prom_we=%h need all 0", prog_we, ioctl_wait, prom_we);
    end else $display("ok reset_release idle");
  endtask

  task automatic test_sdram_basic();
    bit  ok;
    wr_t e, o;
    sync();
    prog_rdy = 1'b1;
    send(22'h0, 8'h11, 1'b1);
    @(negedge clk);
    checks++;
    if (prog_we !== 1'b0) begin
      failures++;
      $display("FAIL basic_lat_n1 prog_we got=%b need=0", prog_we);
    end
    tick();
    @(negedge clk);
    checks++;
    if (prog_we !== 1'b1) begin
      failures++;
      $display("FAIL basic_lat_n2 prog_we got=%b need=1", prog_we);
    end
    send(22'h1, 8'h22, 1'b1);
    wait_obs(2, 30, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL basic_count got=%0d need=2", obs_q.size() - obs_rd);
    end
    while (obs_rd < obs_q.size() && exp_q.size() > 0) begin
      o = obs_q[obs_rd];
      obs_rd++;
      e = exp_q.pop_front();
      checks++;
      if (o.addr !== e.addr || o.data !== e.data || o.mask !== e.mask) begin
        failures++;
        $display("FAIL basic_wr got a=%h d=%h m=%b need a=%h d=%h m=%b", o.addr, o.data, o.mask, e.addr, e.data, e.mask);
      end else $display("ok basic_wr a=%h d=%h m=%b", o.addr, o.data, o.mask);
    end
  endtask

  task automatic test_throughput();
    bit  ok;
    int  prev;
    wr_t e, o;
    sync();
    prog_rdy = 1'b1;
    for (int i = 0; i < 8; i++) send(22'h200 + 22'(i), 8'hA0 + 8'(i), 1'b1);
    wait_obs(8, 30, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL thru_count got=%0d need=8", obs_q.size() - obs_rd);
    end
    prev = -1;
    while (obs_rd < obs_q.size() && exp_q.size() > 0) begin
      o = obs_q[obs_rd];
      obs_rd++;
      e = exp_q.pop_front();
      checks++;
      if (o.addr !== e.addr || o.data !== e.data || o.mask !== e.mask ||
          (prev >= 0 && o.cyc != prev + 1)) begin
        failures++;
        $display("FAIL thru_wr got a=%h d=%h m=%b cyc=%0d need a=%h d=%h m=%b cyc=%0d",
                 o.addr, o.data, o.mask, o.cyc, e.addr, e.data, e.mask, prev + 1);
      end else $display("ok thru_wr a=%h d=%h m=%b cyc=%0d", o.addr, o.data, o.mask, o.cyc);
      prev = o.cyc;
    end
  endtask

  task automatic test_prom();
    bit  ok;
    wr_t e, o;
    sync();
    prog_rdy = 1'b1;
    send(22'(PROM_START + 'h205), 8'h5A, 1'b1);
    @(negedge clk);
    checks++;
    if (prom_we !== 6'h04 || prom_addr !== 8'h05 || prom_data !== 8'h5A) begin
      failures++;
      $display("FAIL prom_hit got we=%h a=%h d=%h need we=04 a=05 d=5a", prom_we, prom_addr, prom_data);
    end else $display("ok prom_hit we=%h a=%h d=%h", prom_we, prom_addr, prom_data);
    tick();
    @(negedge clk);
    checks++;
    if (prom_we !== 6'h00) begin
      failures++;
      $display("FAIL prom_one_cycle got we=%h need=00", prom_we);
    end
    send(22'(PROM_START + 6*256), 8'h77, 1'b1);
    @(negedge clk);
    checks++;
    if (prom_we !== 6'h00) begin
      failures++;
      $display("FAIL prom_beyond got we=%h need=00", prom_we);
    end else $display("ok prom_beyond discarded");
    send(22'(PROM_START + 'h5FF), 8'hC3, 1'b1);
    @(negedge clk);
    checks++;
    if (prom_we !== 6'h20 || prom_addr !== 8'hFF || prom_data !== 8'hC3) begin
      failures++;
      $display("FAIL prom_last got we=%h a=%h d=%h need we=20 a=ff d=c3", prom_we, prom_addr, prom_data);
    end else $display("ok prom_last we=%h a=%h d=%h", prom_we, prom_addr, prom_data);
    send(22'(PROM_START - 1), 8'h3C, 1'b1);
    @(negedge clk);
    checks++;
    if (prom_we !== 6'h00) begin
      failures++;
      $display("FAIL prom_below got we=%h need=00", prom_we);
    end
    wait_obs(1, 20, ok);
    repeat (4) tick();
    checks++;
    if (obs_q.size() - obs_rd != 1) begin
      failures++;
      $display("FAIL prom_sdram_count got=%0d need=1", obs_q.size() - obs_rd);
    end
    if (obs_rd < obs_q.size() && exp_q.size() > 0) begin
      o = obs_q[obs_rd];
      obs_rd++;
      e = exp_q.pop_front();
      checks++;
      if (o.addr !== e.addr || o.data !== e.data || o.mask !== e.mask) begin
        failures++;
        $display("FAIL prom_below_wr got a=%h d=%h m=%b need a=%h d=%h m=%b", o.addr, o.data, o.mask, e.addr, e.data, e.mask);
      end else $display("ok prom_below_wr a=%h d=%h m=%b", o.addr, o.data, o.mask);
    end
  endtask

  task automatic test_signature();
    logic [7:0] good [4];
    logic [7:0] b;
    bit         ok;
    good[0] = 8'he4; good[1] = 8'h64; good[2] = 8'ha5; good[3] = 8'h46;
    for (int run = 0; run < 2; run++) begin
      sync();
      prog_rdy = 1'b1;
      downloading = 1'b0;
      repeat (2) tick();
      downloading = 1'b1;
      tick();
      @(negedge clk);
      checks++;
      if (encrypted !== 1'b0) begin
        failures++;
        $display("FAIL sig_clear run%0d got=%b need=0", run, encrypted);
      end
      for (int i = 0; i < 4; i++) begin
        b = (run == 1 && i == 2) ? 8'h00 : good[i];
        send(22'(i), b, 1'b1);
        if (i == 2) begin
          @(negedge clk);
          checks++;
          if (encrypted !== 1'b0) begin
            failures++;
            $display("FAIL sig_early run%0d got=%b need=0", run, encrypted);
          end
        end
      end
      @(negedge clk);
      checks++;
      if (encrypted !== (run == 0)) begin
        failures++;
        $display("FAIL sig_result run%0d got=%b need=%b", run, encrypted, run == 0);
      end else $display("ok sig_result run%0d encrypted=%b", run, encrypted);
      wait_obs(4, 30, ok);
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL sig_sdram_count run%0d got=%0d need=4", run, obs_q.size() - obs_rd);
      end
      downloading = 1'b0;
      repeat (3) tick();
    end
  endtask

  task automatic test_done();
    int  pulses;
    int  done_cyc;
    bit  ok;
    wr_t e, o;
    sync();
    prog_rdy = 1'b0;
    downloading = 1'b1;
    repeat (3) tick();
    for (int i = 0; i < 3; i++) send(22'h30 + 22'(i), 8'hD0 + 8'(i), 1'b1);
    downloading = 1'b0;
    pulses = 0;
    repeat (10) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0 || prog_we !== 1'b1) begin
      failures++;
      $display("FAIL done_early pulses=%0d we=%b need pulses=0 we=1", pulses, prog_we);
    end else $display("ok done_held_low while stalled");
    prog_rdy = 1'b1;
    done_cyc = -1;
    repeat (15) begin
      @(negedge clk);
      if (done === 1'b1) begin
        pulses++;
        done_cyc = cyc;
      end
    end
    checks++;
    if (pulses != 1) begin
      failures++;
      $display("FAIL done_pulses got=%0d need=1", pulses);
    end else $display("ok done_pulse cyc=%0d", done_cyc);
    wait_obs(3, 10, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL done_sdram_count got=%0d need=3", obs_q.size() - obs_rd);
    end
    while (obs_rd < obs_q.size() && exp_q.size() > 0) begin
      o = obs_q[obs_rd];
      obs_rd++;
      e = exp_q.pop_front();
      checks++;
      if (o.addr !== e.addr || o.data !== e.data || o.mask !== e.mask || done_cyc <= o.cyc) begin
        failures++;
        $display("FAIL done_wr got a=%h d=%h m=%b cyc=%0d need a=%h d=%h m=%b before done cyc=%0d",
                 o.addr, o.data, o.mask, o.cyc, e.addr, e.data, e.mask, done_cyc);
      end else $display("ok done_wr a=%h d=%h m=%b cyc=%0d", o.addr, o.data, o.mask, o.cyc);
    end
  endtask

  // One byte sits in the request registers, so the 4-deep FIFO fills on the 5th push.
  task automatic test_overflow();
    bit  ok;
    wr_t e, o;
    sync();
    prog_rdy = 1'b0;
    for (int i = 0; i < 4; i++) send(22'h40 + 22'(i), 8'h60 + 8'(i), 1'b1);
    @(negedge clk);
    checks++;
    if (ioctl_wait !== 1'b0) begin
      failures++;
      $display("FAIL ovf_wait_early got=%b need=0", ioctl_wait);
    end
    send(22'h44, 8'h64, 1'b1);
    @(negedge clk);
    checks++;
    if (ioctl_wait !== 1'b1 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL ovf_full got wait=%b ovf=%b need wait=1 ovf=0", ioctl_wait, overflow);
    end else $display("ok ovf_full wait=1");
    send(22'h45, 8'h65, 1'b0);
    @(negedge clk);
    checks++;
    if (overflow !== 1'b1) begin
      failures++;
      $display("FAIL ovf_set got=%b need=1", overflow);
    end else $display("ok ovf_set");
    repeat (14) tick();
    checks++;
    if (obs_q.size() != obs_rd || prog_we !== 1'b1) begin
      failures++;
      $display("FAIL ovf_stall got writes=%0d we=%b need writes=0 we=1", obs_q.size() - obs_rd, prog_we);
    end
    prog_rdy = 1'b1;
    wait_obs(5, 30, ok);
    repeat (5) tick();
    checks++;
    if (obs_q.size() - obs_rd != 5) begin
      failures++;
      $display("FAIL ovf_count got=%0d need=5", obs_q.size() - obs_rd);
    end
    while (obs_rd < obs_q.size() && exp_q.size() > 0) begin
      o = obs_q[obs_rd];
      obs_rd++;
      e = exp_q.pop_front();
      checks++;
      if (o.addr !== e.addr || o.data !== e.data || o.mask !== e.mask) begin
        failures++;
        $display("FAIL ovf_wr got a=%h d=%h m=%b need a=%h d=%h m=%b", o.addr, o.data, o.mask, e.addr, e.data, e.mask);
      end else $display("ok ovf_wr a=%h d=%h m=%b", o.addr, o.data, o.mask);
    end
    checks++;
    if (ioctl_wait !== 1'b0 || overflow !== 1'b1) begin
      failures++;
      $display("FAIL ovf_after got wait=%b ovf=%b need wait=0 ovf=1", ioctl_wait, overflow);
    end
  endtask

  task automatic test_rst_mid();
    sync();
    prog_rdy = 1'b0;
    for (int i = 0; i < 6; i++) send(22'h80 + 22'(i), 8'h90 + 8'(i), 1'b0);
    @(negedge clk);
    checks++;
    if (prog_we !== 1'b1 || ioctl_wait !== 1'b1) begin
      failures++;
      $display("FAIL rst_pre got we=%b wait=%b need we=1 wait=1", prog_we, ioctl_wait);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (prog_we !== 1'b0 || ioctl_wait !== 1'b0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid got we=%b wait=%b ovf=%b need all 0", prog_we, ioctl_wait, overflow);
    end else $display("ok rst_mid cleared");
    prog_rdy = 1'b1;
    repeat (10) tick();
    checks++;
    if (obs_q.size() != obs_rd || prog_we !== 1'b0) begin
      failures++;
      $display("FAIL rst_flush got writes=%0d we=%b need writes=0 we=0", obs_q.size() - obs_rd, prog_we);
    end else $display("ok rst_flush fifo empty");
  endtask

  initial begin
    test_reset();
    test_sdram_basic();
    test_throughput();
    test_prom();
    test_signature();
    test_done();
    test_overflow();
    test_rst_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
